ldtu_rx_word_unpacker: RTL

- Back-end receiver for the LiTe-DTU 32-bit output word stream, which carries idle pattern 0xEAAAAAAA when the DTU FIFO is empty and data words otherwise.
- Classifies each incoming word and acquires word lock on a run of idle words. While locked, it buffers data words in a 16-deep FIFO for a downstream consumer using a read handshake.
- Used on the test/readout side to recover the payload sent by the DTU output FIFO.

---
 rtl/ldtu_rx_word_unpacker.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ldtu_rx_word_unpacker.sv
// ldtu_rx_word_unpacker
// Receiver for the LiTe-DTU 32-bit word stream. Each valid word is classified
// as idle (0xEAAAAAAA), resync (0x5A5A5A5A) or data. A run of LOCK_IDLES idle
// words acquires lock. While locked, data words go into a 16-deep FIFO that
// a consumer drains one word per read_signal pulse.
//
// Optional feature macro: LDTU_RX_HAMM_EN
//   When defined, FIFO entries are stored Hamming SEC encoded (32 -> 38 bits).
//   On read, a single flipped bit is corrected and SeuError strobes with
//   data_valid.
//   When undefined, entries are plain 32-bit words and SeuError is always 0.
//
// Handshake: word_valid qualifies data_in_32 for one cycle, and the receiver
// always accepts it (there is no ready). read_signal pops the head word when
// the FIFO is not empty. The word appears on data_out_32 one cycle later,
// with data_valid high for that cycle only.
module ldtu_rx_word_unpacker #(
   parameter int          Nbits_32       = 32,
   parameter int          FifoDepth_buff = 16,
   parameter int          bits_ptr       = 4,
   parameter int          LOCK_IDLES     = 4,
   parameter logic [31:0] idle_patternEA = 32'hEAAAAAAA,
   parameter logic [31:0] idle_pattern5A = 32'h5A5A5A5A
) (
   input  logic                CLK,
   input  logic                rst_b,
   input  logic                word_valid,
   input  logic [Nbits_32-1:0] data_in_32,
   input  logic                read_signal,
   output logic [Nbits_32-1:0] data_out_32,
   output logic                data_valid,
   output logic                empty_signal,
   output logic                full_signal,
   output logic                overflow,
   output logic                locked,
   output logic                SeuError
);

`ifdef LDTU_RX_HAMM_EN
   localparam int MEM_W = Nbits_32 + 6;

   // Place the data bits at the non-power-of-two positions 1..38, then set
   // each check bit so that the XOR of the set-bit positions is zero.
   function automatic logic [MEM_W-1:0] hamm_enc(input logic [Nbits_32-1:0] d);
      logic [MEM_W-1:0] cw;
      logic [5:0]       syn;
      int               k;
      cw  = '0;
      syn = '0;
      k   = 0;
      for (int p = 1; p <= MEM_W; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = d[k];
            k++;
         end
      end
      for (int p = 1; p <= MEM_W; p++) begin
         if (cw[p-1]) syn = syn ^ p[5:0];
      end
      for (int i = 0; i < 6; i++) cw[(1 << i) - 1] = syn[i];
      return cw;
   endfunction

   // The syndrome is the XOR of the positions of all set bits. It is non-zero
   // exactly at the position of a single flipped bit.
   function automatic logic [5:0] hamm_syn(input logic [MEM_W-1:0] cw);
      logic [5:0] syn;
      syn = '0;
      for (int p = 1; p <= MEM_W; p++) begin
         if (cw[p-1]) syn = syn ^ p[5:0];
      end
      return syn;
   endfunction

   function automatic logic [Nbits_32-1:0] hamm_dec(input logic [MEM_W-1:0] cw_in,
                                                   input logic [5:0] syn);
      logic [MEM_W-1:0]    cw;
      logic [Nbits_32-1:0] d;
      int                  k;
      cw = cw_in;
      d  = '0;
      k  = 0;
      for (int p = 1; p <= MEM_W; p++) begin
         if (syn == p[5:0]) cw[p-1] = ~cw[p-1];
      end
      for (int p = 1; p <= MEM_W; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[k] = cw[p-1];
            k++;
         end
      end
      return d;
   endfunction
`else
   localparam int MEM_W = Nbits_32;
`endif

   typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_IDLES);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [bits_ptr:0]   wr_ptr_q, rd_ptr_q;
   logic [MEM_W-1:0]    mem_q [FifoDepth_buff];
   logic [Nbits_32-1:0] dout_q;
   logic                valid_q, seu_q, ovf_q;

   logic                is_ea, is_5a, is_data;
   logic                empty_w, full_w, rd_en, wr_req, wr_en;
   logic [MEM_W-1:0]    wr_word, head_raw;
   logic [Nbits_32-1:0] head_data;
   logic                head_err;

   // Classify the incoming word. Without word_valid nothing is classified.
   always_comb begin
      is_ea   = word_valid && (data_in_32 == idle_patternEA);
      is_5a   = word_valid && (data_in_32 == idle_pattern5A);
      is_data = word_valid && !is_ea && !is_5a;
   end

   // FSM state and idle-run counter registers
   always_ff @(posedge CLK or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= ST_SEARCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: count idles in SEARCH and lock on the LOCK_IDLES-th one;
   // a resync word drops lock.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_SEARCH: begin
            if (is_ea) begin
               if (cnt_q < LOCK_N) cnt_d = cnt_q + 4'd1;
               if (cnt_q >= LOCK_N - 4'd1) state_d = ST_LOCKED;
            end else if (is_data || is_5a) begin
               cnt_d = '0;
            end
         end
         default: begin
            if (is_5a) begin
               state_d = ST_SEARCH;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // FSM outputs: the lock flag is the state itself.
   always_comb begin
      locked = (state_q == ST_LOCKED);
   end

   // FIFO status and enables. A write into a full FIFO is still accepted
   // when a pop frees the head slot on the same edge.
   always_comb begin
      empty_w = (wr_ptr_q == rd_ptr_q);
      full_w  = (wr_ptr_q[bits_ptr] != rd_ptr_q[bits_ptr]) &&
                (wr_ptr_q[bits_ptr-1:0] == rd_ptr_q[bits_ptr-1:0]);
      rd_en   = read_signal && !empty_w;
      wr_req  = locked && is_data;
      wr_en   = wr_req && (!full_w || rd_en);
   end

   // Encode on write and decode the head entry before the output register.
   always_comb begin
`ifdef LDTU_RX_HAMM_EN
      wr_word   = hamm_enc(data_in_32);
      head_raw  = mem_q[rd_ptr_q[bits_ptr-1:0]];
      head_err  = (hamm_syn(head_raw) != 6'd0);
      head_data = hamm_dec(head_raw, hamm_syn(head_raw));
`else
      wr_word   = data_in_32;
      head_raw  = mem_q[rd_ptr_q[bits_ptr-1:0]];
      head_err  = 1'b0;
      head_data = head_raw;
`endif
   end

   // FIFO storage. There is no reset here: the pointers alone define which
   // entries are valid.
   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_ptr_q[bits_ptr-1:0]] <= wr_word;
   end

   // Pointers, sticky overflow flag, and registered read port
   always_ff @(posedge CLK or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         dout_q   <= idle_patternEA;
         valid_q  <= 1'b0;
         seu_q    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (wr_req && !wr_en) ovf_q <= 1'b1;
         valid_q <= 1'b0;
         seu_q   <= 1'b0;
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            dout_q   <= head_data;
            valid_q  <= 1'b1;
            seu_q    <= head_err;
         end else if (read_signal) begin
            dout_q <= idle_patternEA;
         end
      end
   end

   assign data_out_32  = dout_q;
   assign data_valid   = valid_q;
   assign empty_signal = empty_w;
   assign full_signal  = full_w;
   assign overflow     = ovf_q;
   assign SeuError     = seu_q;

endmodule
